adc_stream_fifo: RTL and testbench
==================================

Name: adc_stream_fifo

Overview:
- Synchronous single-clock FIFO buffering 32-bit ADC sample words between the ADC capture/packing logic (producer) and the register/bus readout path (consumer).
- First-word-fall-through: head word is visible on pop_data whenever pop_valid=1.
- Reports fill level and a sticky overrun flag, set when the producer pushes while full; the flag is cleared by an explicit strobe.

Parameters:
- DEPTH_WORDS, 8, storage depth in 32-bit words; power of two, >=2.
- LEVEL_W (localparam), $clog2(DEPTH_WORDS)+1, width of level_words; 4 for the default.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- push_valid  in  1  producer offers push_data this cycle.
- push_data  in  32  sample word to write.
- push_ready  out  1  FIFO can accept; equals !full, combinational from registered state only.
- pop_valid  out  1  head word available; equals !empty.
- pop_data  out  32  head word, valid when pop_valid=1; read combinationally from storage at rd_ptr.
- pop_ready  in  1  consumer accepts head word.
- level_words  out  LEVEL_W  current occupancy, 0..DEPTH_WORDS.
- overrun_sticky  out  1  set on any dropped push; holds until cleared.
- overrun_clear  in  1  single-cycle strobe; clears overrun_sticky.

Behaviour:
- Reset (rst=1 at a clk edge): wr_ptr=0, rd_ptr=0, count=0, overrun_sticky=0. After reset: push_ready=1, pop_valid=0, level_words=0. Storage contents are not reset; pop_data is don't-care while empty.
- Write fires when push_valid & push_ready: mem[wr_ptr] <= push_data; wr_ptr increments modulo DEPTH_WORDS.
- Read fires when pop_valid & pop_ready: rd_ptr increments modulo DEPTH_WORDS. New head is visible the next cycle (zero added latency).
- Pointers use log2(DEPTH_WORDS) bits and wrap naturally. Occupancy comes from a separate count register (LEVEL_W bits).
- Count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on simultaneous write and read, or on no transfer.
- full = (count==DEPTH_WORDS); empty = (count==0).
- Write to an empty FIFO: data appears on pop_data with pop_valid=1 the cycle after the write edge.
- Full with simultaneous push_valid and pop_ready: push_ready is still 0, so there is no pass-through. The read proceeds, the push is dropped and counts as an overrun.
- Empty with simultaneous push and pop_ready: only the write occurs. There is no bypass.
- Overrun: push_valid & !push_ready at a clk edge sets overrun_sticky=1. Data is discarded and FIFO contents, pointers and count are unchanged.
- overrun_clear=1 at an edge sets overrun_sticky=0. If an overrun event happens in the same cycle, set wins and the flag stays 1.
- Ordering is strictly first-in first-out. No word is lost except dropped overrun pushes.
- Reset asserted mid-operation empties the FIFO on that edge and overrides any simultaneous push or pop.

Optional Feature:
- Macro ADC_STREAM_FIFO_DROP_COUNT_EN.
- When defined: adds output drop_count[15:0], reset to 0.
  - Increments on each dropped push and saturates at 16'hFFFF.
  - Cleared by overrun_clear; increment wins on the same cycle, giving a result of 1.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package adc_stream_pkg: ADC_WORD_W=32 constant and a typedef adc_word_t for the 32-bit sample word, shared with the ADC capture and readout blocks.
- One sub-module, adc_stream_fifo_mem: a DEPTH_WORDS x 32 register array with synchronous write port and asynchronous read port.
- Pointers, count, handshake and flag logic stay in adc_stream_fifo.

Test Plan:
- Reset sequence, 2 cycles of rst=1 then release -> level_words=0, overrun_sticky=0, pop_valid=0, push_ready=1.
- Push 8 words 32'hA5A50000..32'hA5A50007 back-to-back with pop_ready=0 -> push_ready=1 before each push; afterwards level_words=8, push_ready=0.
- While full, push 32'hDEADBEEF for one cycle -> overrun_sticky=1, level_words stays 8, contents unchanged.
- Hold pop_ready=1 and drain -> pop_data = 32'hA5A50000+n in order for n=0..7, no DEADBEEF; then level_words=0, pop_valid=0, and overrun_sticky still 1.
- Pulse overrun_clear for one cycle -> overrun_sticky=0 next cycle. Repeat with an overrun push in the same cycle -> overrun_sticky remains 1.
- Continuous simultaneous push/pop at level 3 for 20 cycles (pointer wrap) -> level_words stays 3, FIFO order preserved. Assert rst mid-stream -> level_words=0 the next cycle.

Source files
------------

// File: rtl/adc_stream_pkg.sv
// Shared ADC sample-word definitions.
// Used by the ADC capture/packing logic, the stream FIFO and the readout path
// so that all of them agree on the sample word width.
package adc_stream_pkg;

  localparam int unsigned ADC_WORD_W = 32;

  typedef logic [ADC_WORD_W-1:0] adc_word_t;

endpackage : adc_stream_pkg

// File: rtl/adc_stream_fifo_mem.sv
// Register-array storage for adc_stream_fifo.
// DEPTH_WORDS x ADC_WORD_W words, synchronous write, asynchronous read.
// Contents are not reset.
//
// Ports:
//   clk      in   system clock, write on rising edge
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   word to store
//   rd_addr  in   read address
//   rd_data  out  word at rd_addr (combinational)
module adc_stream_fifo_mem
  import adc_stream_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 8,
  localparam int unsigned ADDR_W     = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  adc_word_t         wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output adc_word_t         rd_data
);

  adc_word_t mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule : adc_stream_fifo_mem

// File: rtl/adc_stream_fifo.sv
// Single-clock first-word-fall-through FIFO for 32-bit ADC sample words,
// between the ADC capture/packing logic and the register/bus readout path.
// Reports occupancy and a sticky overrun flag for pushes dropped while full.
//
// Optional feature: define ADC_STREAM_FIFO_DROP_COUNT_EN to add a saturating
// 16-bit count of dropped pushes (drop_count), cleared by overrun_clear.
//
// Ports:
//   clk             in   system clock, rising edge
//   rst             in   synchronous active-high reset
//   push_valid      in   producer offers push_data
//   push_data       in   sample word to write
//   push_ready      out  FIFO not full
//   pop_valid       out  FIFO not empty
//   pop_data        out  head word (valid when pop_valid)
//   pop_ready       in   consumer accepts head word
//   level_words     out  occupancy, 0..DEPTH_WORDS
//   overrun_sticky  out  set on dropped push, held until cleared
//   overrun_clear   in   strobe clearing overrun_sticky
//   drop_count      out  (optional) saturating dropped-push count
module adc_stream_fifo
  import adc_stream_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 8,
  localparam int unsigned LEVEL_W    = $clog2(DEPTH_WORDS) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_valid,
  input  adc_word_t          push_data,
  output logic               push_ready,
  output logic               pop_valid,
  output adc_word_t          pop_data,
  input  logic               pop_ready,
  output logic [LEVEL_W-1:0] level_words,
  output logic               overrun_sticky,
  input  logic               overrun_clear
`ifdef ADC_STREAM_FIFO_DROP_COUNT_EN
  ,
  output logic [15:0]        drop_count
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH_WORDS);

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] count;
  logic               full;
  logic               empty;
  logic               wr_fire;
  logic               rd_fire;
  logic               drop;

  assign full        = (count == LEVEL_W'(DEPTH_WORDS));
  assign empty       = (count == '0);
  assign push_ready  = !full;
  assign pop_valid   = !empty;
  assign level_words = count;

  // No pass-through when full and no bypass when empty: both handshakes
  // depend only on registered occupancy.
  assign wr_fire = push_valid && push_ready;
  assign rd_fire = pop_valid && pop_ready;
  assign drop    = push_valid && !push_ready;

  adc_stream_fifo_mem #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_fire && !rst),
    .wr_addr (wr_ptr),
    .wr_data (push_data),
    .rd_addr (rd_ptr),
    .rd_data (pop_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      overrun_sticky <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + LEVEL_W'(1);
        2'b01:   count <= count - LEVEL_W'(1);
        default: count <= count;
      endcase
      // A new overrun takes priority over a same-cycle clear.
      if (drop) begin
        overrun_sticky <= 1'b1;
      end else if (overrun_clear) begin
        overrun_sticky <= 1'b0;
      end
    end
  end

`ifdef ADC_STREAM_FIFO_DROP_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop) begin
      // Clear and drop together restart the count at one.
      if (overrun_clear) begin
        drop_count <= 16'd1;
      end else if (drop_count != '1) begin
        drop_count <= drop_count + 16'd1;
      end
    end else if (overrun_clear) begin
      drop_count <= '0;
    end
  end
`endif

endmodule : adc_stream_fifo

// File: tb/tb_adc_stream_fifo.sv
// Directed self-checking bench for adc_stream_fifo (DEPTH_WORDS = 8).
module tb_adc_stream_fifo;
  import adc_stream_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_valid;
  adc_word_t   push_data;
  logic        push_ready;
  logic        pop_valid;
  adc_word_t   pop_data;
  logic        pop_ready;
  logic [3:0]  level_words;
  logic        overrun_sticky;
  logic        overrun_clear;
`ifdef ADC_STREAM_FIFO_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  adc_stream_fifo #(
    .DEPTH_WORDS (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .push_valid     (push_valid),
    .push_data      (push_data),
    .push_ready     (push_ready),
    .pop_valid      (pop_valid),
    .pop_data       (pop_data),
    .pop_ready      (pop_ready),
    .level_words    (level_words),
    .overrun_sticky (overrun_sticky),
    .overrun_clear  (overrun_clear)
`ifdef ADC_STREAM_FIFO_DROP_COUNT_EN
    ,
    .drop_count     (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++; if (level_words !== 4'd0) begin n_bad++; $display("FAIL reset_level: got %0d expected 0", level_words); end
    n_cmp++; if (overrun_sticky !== 1'b0) begin n_bad++; $display("FAIL reset_sticky: got %b expected 0", overrun_sticky); end
    n_cmp++; if (pop_valid !== 1'b0) begin n_bad++; $display("FAIL reset_pop_valid: got %b expected 0", pop_valid); end
    n_cmp++; if (push_ready !== 1'b1) begin n_bad++; $display("FAIL reset_push_ready: got %b expected 1", push_ready); end
`ifdef ADC_STREAM_FIFO_DROP_COUNT_EN
    n_cmp++; if (drop_count !== 16'd0) begin n_bad++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
`endif
  endtask

  task automatic test_fill(input logic [31:0] base);
    for (int i = 0; i < 8; i++) begin
      push_valid = 1'b1;
      push_data  = base + 32'(i);
      n_cmp++; if (push_ready !== 1'b1) begin n_bad++; $display("FAIL fill_push_ready[%0d]: got %b expected 1", i, push_ready); end
      tick();
    end
    push_valid = 1'b0;
    n_cmp++; if (level_words !== 4'd8) begin n_bad++; $display("FAIL fill_level: got %0d expected 8", level_words); end
    n_cmp++; if (push_ready !== 1'b0) begin n_bad++; $display("FAIL fill_push_ready_full: got %b expected 0", push_ready); end
    n_cmp++; if (pop_data !== base) begin n_bad++; $display("FAIL fill_head: got %h expected %h", pop_data, base); end
  endtask

  task automatic test_overrun();
    push_valid = 1'b1;
    push_data  = 32'hDEADBEEF;
    tick();
    push_valid = 1'b0;
    n_cmp++; if (overrun_sticky !== 1'b1) begin n_bad++; $display("FAIL overrun_sticky: got %b expected 1", overrun_sticky); end
    n_cmp++; if (level_words !== 4'd8) begin n_bad++; $display("FAIL overrun_level: got %0d expected 8", level_words); end
    n_cmp++; if (pop_data !== 32'hA5A50000) begin n_bad++; $display("FAIL overrun_head: got %h expected a5a50000", pop_data); end
`ifdef ADC_STREAM_FIFO_DROP_COUNT_EN
    n_cmp++; if (drop_count !== 16'd1) begin n_bad++; $display("FAIL overrun_drop_count: got %0d expected 1", drop_count); end
`endif
  endtask

  task automatic test_drain(input logic [31:0] base);
    pop_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      n_cmp++; if (pop_valid !== 1'b1) begin n_bad++; $display("FAIL drain_valid[%0d]: got %b expected 1", n, pop_valid); end
      n_cmp++; if (pop_data !== base + 32'(n)) begin n_bad++; $display("FAIL drain_data[%0d]: got %h expected %h", n, pop_data, base + 32'(n)); end
      tick();
    end
    pop_ready = 1'b0;
    n_cmp++; if (level_words !== 4'd0) begin n_bad++; $display("FAIL drain_level: got %0d expected 0", level_words); end
    n_cmp++; if (pop_valid !== 1'b0) begin n_bad++; $display("FAIL drain_pop_valid: got %b expected 0", pop_valid); end
    n_cmp++; if (overrun_sticky !== 1'b1) begin n_bad++; $display("FAIL drain_sticky: got %b expected 1", overrun_sticky); end
  endtask

  task automatic test_clear();
    overrun_clear = 1'b1;
    tick();
    overrun_clear = 1'b0;
    n_cmp++; if (overrun_sticky !== 1'b0) begin n_bad++; $display("FAIL clear_sticky: got %b expected 0", overrun_sticky); end
`ifdef ADC_STREAM_FIFO_DROP_COUNT_EN
    n_cmp++; if (drop_count !== 16'd0) begin n_bad++; $display("FAIL clear_drop_count: got %0d expected 0", drop_count); end
`endif
    test_fill(32'hA5A60000);
    // Overrun and clear in the same cycle: set must win.
    overrun_clear = 1'b1;
    push_valid    = 1'b1;
    push_data     = 32'hDEADBEEF;
    tick();
    overrun_clear = 1'b0;
    push_valid    = 1'b0;
    n_cmp++; if (overrun_sticky !== 1'b1) begin n_bad++; $display("FAIL clear_vs_set_sticky: got %b expected 1", overrun_sticky); end
    n_cmp++; if (level_words !== 4'd8) begin n_bad++; $display("FAIL clear_vs_set_level: got %0d expected 8", level_words); end
`ifdef ADC_STREAM_FIFO_DROP_COUNT_EN
    n_cmp++; if (drop_count !== 16'd1) begin n_bad++; $display("FAIL clear_vs_set_drop_count: got %0d expected 1", drop_count); end
`endif
    test_drain(32'hA5A60000);
  endtask

  // Empty FIFO with push and pop_ready together: only the write happens.
  task automatic test_empty_push_pop();
    push_valid = 1'b1;
    pop_ready  = 1'b1;
    push_data  = 32'h12345678;
    n_cmp++; if (pop_valid !== 1'b0) begin n_bad++; $display("FAIL empty_no_bypass: got %b expected 0", pop_valid); end
    tick();
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    n_cmp++; if (level_words !== 4'd1) begin n_bad++; $display("FAIL empty_pp_level: got %0d expected 1", level_words); end
    n_cmp++; if (pop_data !== 32'h12345678) begin n_bad++; $display("FAIL empty_pp_head: got %h expected 12345678", pop_data); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expq[$];
    expq.push_back(32'h12345678);
    // Bring level from 1 to 3.
    for (int i = 1; i <= 2; i++) begin
      push_valid = 1'b1;
      push_data  = 32'hB0000000 + 32'(i);
      expq.push_back(push_data);
      tick();
    end
    push_valid = 1'b0;
    n_cmp++; if (level_words !== 4'd3) begin n_bad++; $display("FAIL b2b_start_level: got %0d expected 3", level_words); end
    push_valid = 1'b1;
    pop_ready  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      push_data = 32'hC0000000 + 32'(c);
      n_cmp++; if (pop_data !== expq[0]) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h expected %h", c, pop_data, expq[0]); end
      expq.push_back(push_data);
      void'(expq.pop_front());
      tick();
      n_cmp++; if (level_words !== 4'd3) begin n_bad++; $display("FAIL b2b_level[%0d]: got %0d expected 3", c, level_words); end
    end
    // Reset mid-stream with push and pop still requested.
    push_data = 32'hEEEEEEEE;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    n_cmp++; if (level_words !== 4'd0) begin n_bad++; $display("FAIL midrst_level: got %0d expected 0", level_words); end
    n_cmp++; if (pop_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_pop_valid: got %b expected 0", pop_valid); end
    n_cmp++; if (push_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_push_ready: got %b expected 1", push_ready); end
    n_cmp++; if (overrun_sticky !== 1'b0) begin n_bad++; $display("FAIL midrst_sticky: got %b expected 0", overrun_sticky); end
  endtask

  initial begin
    rst           = 1'b1;
    push_valid    = 1'b0;
    push_data     = '0;
    pop_ready     = 1'b0;
    overrun_clear = 1'b0;
    #1;
    test_reset();
    test_fill(32'hA5A50000);
    test_overrun();
    test_drain(32'hA5A50000);
    test_clear();
    test_empty_push_pop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_adc_stream_fifo
